// File: rtl/serv_dbus_timer.sv
// Wishbone-style dbus responder for SERV with a 64-bit RISC-V machine timer.
// Optional GPIO output register is enabled with `define SERV_DBUS_TIMER_GPIO_EN.
module serv_dbus_timer #(
  parameter int LATENCY  = 1,
  parameter int PRESCALE = 1,
  parameter int GPIO_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cyc,
  input  logic              i_we,
  input  logic [3:0]        i_sel,
  input  logic [31:0]       i_adr,
  input  logic [31:0]       i_dat,
  output logic [31:0]       o_rdt,
  output logic              o_ack,
  output logic              o_timer_irq,
  output logic [GPIO_W-1:0] o_gpio
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  wait_cnt;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [2:0]  req_adr;
  logic [31:0] req_dat;
  logic [15:0] presc;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] rdata;
  logic        commit;
  logic        tick;
  logic        unused_adr;

  // Only adr[4:2] matters; the interconnect has already selected this region.
  assign unused_adr = ^{i_adr[31:5], i_adr[1:0]};

  assign commit = (state == ACK) && req_we && (req_sel != 4'b0000);
  assign tick   = (presc == 16'(PRESCALE - 1));

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      req_we   <= 1'b0;
      req_sel  <= '0;
      req_adr  <= '0;
      req_dat  <= '0;
    end else begin
      case (state)
        IDLE: if (i_cyc) begin
          req_we  <= i_we;
          req_sel <= i_sel;
          req_adr <= i_adr[4:2];
          req_dat <= i_dat;
          if (LATENCY > 0) begin
            state    <= WAIT;
            wait_cnt <= 4'(LATENCY - 1);
          end else begin
            state <= ACK;
          end
        end
        WAIT: if (wait_cnt == 4'd0) state <= ACK;
              else wait_cnt <= wait_cnt - 4'd1;
        ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 16'd1;
  end

  // A software write to either half wins over the tick and drops that increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
      o_timer_irq <= 1'b0;
    end else begin
      if (commit && req_adr == 3'd0)
        mtime[31:0] <= merge(mtime[31:0], req_dat, req_sel);
      else if (commit && req_adr == 3'd1)
        mtime[63:32] <= merge(mtime[63:32], req_dat, req_sel);
      else if (tick)
        mtime <= mtime + 64'd1;
      if (commit && req_adr == 3'd2)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], req_dat, req_sel);
      if (commit && req_adr == 3'd3)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], req_dat, req_sel);
      o_timer_irq <= (mtime >= mtimecmp);
    end
  end

`ifdef SERV_DBUS_TIMER_GPIO_EN
  logic [GPIO_W-1:0] gpio;
  logic [31:0]       gpio_wr;
  assign gpio_wr = merge(32'(gpio), req_dat, req_sel);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) gpio <= '0;
    else if (commit && req_adr == 3'd4) gpio <= gpio_wr[GPIO_W-1:0];
  end
  assign o_gpio = gpio;
`else
  logic [31:0] gpio;
  assign gpio   = '0;
  assign o_gpio = '0;
`endif

  always_comb begin
    rdata = '0;
    case (req_adr)
      3'd0: rdata = mtime[31:0];
      3'd1: rdata = mtime[63:32];
      3'd2: rdata = mtimecmp[31:0];
      3'd3: rdata = mtimecmp[63:32];
      3'd4: rdata = 32'(gpio);
      3'd5: rdata = 32'(PRESCALE);
      default: rdata = '0;
    endcase
  end

  assign o_ack = (state == ACK);
  assign o_rdt = (state == ACK && !req_we) ? rdata : 32'd0;

endmodule

// File: tb/tb_serv_dbus_timer.sv
// Randomized self-checking bench for serv_dbus_timer against a time-based timer model.
// Honours SERV_DBUS_TIMER_GPIO_EN the same way as the design.
module tb_serv_dbus_timer;

  localparam int LAT = 3;
  localparam int P   = 4;
  localparam int GW  = 8;
`ifdef SERV_DBUS_TIMER_GPIO_EN
  localparam bit GPIO_EN = 1'b1;
`else
  localparam bit GPIO_EN = 1'b0;
`endif

  logic          clk, rst_n, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dat, rdt;
  logic          ack, irq;
  logic [GW-1:0] gpio;

  int compared = 0;
  int mismatched = 0;
  int edges = 0;

  // Model: mtime is a base value plus the ticks that elapsed since it was set.
  logic [63:0] mt_base, mt_prev, cmp_m, cmp_prev;
  int          mt_edge, mt_prev_edge, cmp_edge;
  logic [31:0] gpio_m;

  serv_dbus_timer #(.LATENCY(LAT), .PRESCALE(P), .GPIO_W(GW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cyc(cyc), .i_we(we), .i_sel(sel),
    .i_adr(adr), .i_dat(dat), .o_rdt(rdt), .o_ack(ack),
    .o_timer_irq(irq), .o_gpio(gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges = 0;
    else edges = edges + 1;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mtime_at(input int k);
    if (k >= mt_edge) return mt_base + 64'(k / P - mt_edge / P);
    return mt_prev + 64'(k / P - mt_prev_edge / P);
  endfunction

  function automatic logic [63:0] cmp_at(input int k);
    return (k >= cmp_edge) ? cmp_m : cmp_prev;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a, input int k);
    logic [63:0] v;
    case (a)
      3'd0: begin v = mtime_at(k); return v[31:0]; end
      3'd1: begin v = mtime_at(k); return v[63:32]; end
      3'd2: begin v = cmp_at(k); return v[31:0]; end
      3'd3: begin v = cmp_at(k); return v[63:32]; end
      3'd4: return GPIO_EN ? gpio_m : 32'd0;
      3'd5: return 32'(P);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mt_base = '0; mt_prev = '0; mt_edge = 0; mt_prev_edge = 0;
    cmp_m = '1; cmp_prev = '1; cmp_edge = 0; gpio_m = '0;
  endtask

  task automatic model_write(input logic [2:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int w);
    logic [63:0] v;
    logic [31:0] g;
    if (s == 4'b0000) return;
    case (a)
      3'd0, 3'd1: begin
        v = mtime_at(w - 1);
        if (a == 3'd0) v[31:0] = bmerge(v[31:0], d, s);
        else v[63:32] = bmerge(v[63:32], d, s);
        mt_prev = mt_base; mt_prev_edge = mt_edge;
        mt_base = v; mt_edge = w;
      end
      3'd2, 3'd3: begin
        v = cmp_m;
        if (a == 3'd2) v[31:0] = bmerge(v[31:0], d, s);
        else v[63:32] = bmerge(v[63:32], d, s);
        cmp_prev = cmp_m; cmp_m = v; cmp_edge = w;
      end
      3'd4: if (GPIO_EN) begin
        g = bmerge(gpio_m, d, s);
        gpio_m = {{(32-GW){1'b0}}, g[GW-1:0]};
      end
      default: ;
    endcase
  endtask

  // One full transaction starting at a negedge with the FSM idle; returns at a negedge.
  task automatic bus_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit drop_early);
    int n;
    bit got;
    logic [31:0] r, exp;
    r = $urandom();
    cyc = 1'b1; we = w; sel = s; dat = d;
    adr = {r[31:5], a, r[1:0]};
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack === 1'b1) got = 1;
      else if (drop_early) cyc = 1'b0;
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL ack_latency: no ack within 40 cycles (adr %0d), want %0d", a, LAT + 1);
    end else if (n != LAT + 1) begin
      mismatched++;
      $display("FAIL ack_latency: got %0d cycles, want %0d (adr %0d)", n, LAT + 1, a);
    end
    if (got) begin
      exp = w ? 32'd0 : exp_read(a, edges);
      compared++;
      if (rdt !== exp) begin
        mismatched++;
        $display("FAIL rdata adr %0d we %0b: got %h, want %h", a, w, rdt, exp);
      end
      if (w) model_write(a, d, s, edges + 1);
    end
    cyc = 1'b0;
    @(negedge clk);
    compared++;
    if (ack !== 1'b0 || rdt !== 32'd0) begin
      mismatched++;
      $display("FAIL ack_pulse: ack %b rdt %h, want 0 and 0", ack, rdt);
    end
    if (w && a == 3'd4) begin
      compared++;
      if (gpio !== gpio_m[GW-1:0]) begin
        mismatched++;
        $display("FAIL gpio_out: got %h, want %h", gpio, gpio_m[GW-1:0]);
      end
    end
  endtask

  task automatic test_reset();
    cyc = 0; we = 0; sel = 0; adr = 0; dat = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (ack !== 1'b0 || rdt !== 32'd0 || irq !== 1'b0 || gpio !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: ack %b rdt %h irq %b gpio %h, want all 0", ack, rdt, irq, gpio);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus_xfer(1'b0, 3'd2, 32'd0, 4'h0, 1'b0);
    bus_xfer(1'b0, 3'd3, 32'd0, 4'h0, 1'b0);
    bus_xfer(1'b0, 3'd5, 32'd0, 4'h0, 1'b0);
  endtask

  task automatic test_prescale();
    repeat (40) @(negedge clk);
    bus_xfer(1'b0, 3'd0, 32'd0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 60)) @(negedge clk);
      bus_xfer(1'b0, 3'(i % 2), 32'd0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_gpio();
    bus_xfer(1'b1, 3'd4, 32'h0000_00A5, 4'b0001, 1'b0);
    bus_xfer(1'b0, 3'd4, 32'd0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus_xfer(1'b1, 3'd4, $urandom(), 4'($urandom_range(0, 15)), 1'b0);
      bus_xfer(1'b0, 3'd4, 32'd0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_irq();
    bit ex;
    logic [63:0] m, c;
    bus_xfer(1'b1, 3'd1, 32'd0, 4'hF, 1'b0);
    bus_xfer(1'b1, 3'd0, 32'h100, 4'hF, 1'b0);
    bus_xfer(1'b1, 3'd3, 32'd0, 4'hF, 1'b0);
    bus_xfer(1'b1, 3'd2, 32'h11E, 4'hF, 1'b0);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      m = mtime_at(edges - 1); c = cmp_at(edges - 1);
      ex = (m >= c);
      compared++;
      if (irq !== ex) begin
        mismatched++;
        $display("FAIL irq_rise cycle %0d: got %b, want %b", i, irq, ex);
      end
    end
    bus_xfer(1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      m = mtime_at(edges - 1); c = cmp_at(edges - 1);
      ex = (m >= c);
      compared++;
      if (irq !== ex) begin
        mismatched++;
        $display("FAIL irq_fall cycle %0d: got %b, want %b", i, irq, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    for (int ph = 0; ph < 4; ph++) begin
      repeat (ph) @(negedge clk);
      bus_xfer(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 1'b0);
      bus_xfer(1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 1'b0);
      bus_xfer(1'b0, 3'd0, 32'd0, 4'h0, 1'b0);
      bus_xfer(1'b0, 3'd1, 32'd0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      v = $urandom();
      bus_xfer(1'b1, 3'(2 + i % 2), v, 4'hF, 1'b0);
      bus_xfer(1'b0, 3'(2 + i % 2), 32'd0, 4'h0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      bus_xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_mid();
    cyc = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h8; dat = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    cyc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if (ack !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_mid_ack: got %b, want 0", ack);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus_xfer(1'b0, 3'd2, 32'd0, 4'h0, 1'b0);
    bus_xfer(1'b0, 3'd3, 32'd0, 4'h0, 1'b0);
    bus_xfer(1'b1, 3'd2, 32'h55, 4'hF, 1'b1);
    bus_xfer(1'b0, 3'd2, 32'd0, 4'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_gpio();
    test_irq();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
